// File: rtl/adder_arb_pkg.sv
// Shared types, defaults and adder arithmetic for adder_rr_arbiter.
package adder_arb_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_t;

  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned MAX_WIDTH   = 64;

  typedef struct packed {
    logic                 ovf;
    logic                 cout;
    logic [MAX_WIDTH-1:0] sum;
  } add_res_t;

  // Add two w-bit operands held zero-extended in MAX_WIDTH containers.
  // Caller keeps only sum[w-1:0]; bits above may hold the carry.
  function automatic add_res_t add_calc(input logic [MAX_WIDTH-1:0] a,
                                        input logic [MAX_WIDTH-1:0] b,
                                        input logic                 cin,
                                        input int unsigned          w);
    logic [MAX_WIDTH:0] full;
    logic [6:0]         wi;
    logic [5:0]         wm;
    add_res_t           r;
    wi     = w[6:0];
    wm     = 6'(w - 1);
    full   = {1'b0, a} + {1'b0, b} + {{MAX_WIDTH{1'b0}}, cin};
    r.sum  = full[MAX_WIDTH-1:0];
    r.cout = full[wi];
    r.ovf  = (a[wm] == b[wm]) && (full[{1'b0, wm}] != a[wm]);
    return r;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first valid requester at or after i_ptr.
module rr_priority_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [ID_W-1:0]    i_ptr,
  input  logic               i_enable,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_winner,
  output logic               o_found
);

  localparam logic [ID_W:0] NR = (ID_W + 1)'(NUM_REQ);

  logic [2*NUM_REQ-1:0] w_rot;
  logic [NUM_REQ-1:0]   w_scan;
  logic [ID_W:0]        w_cnt;
  logic [ID_W:0]        w_off;
  logic [ID_W:0]        w_sum;

  // Rotating the doubled vector puts requester i_ptr at bit 0.
  assign w_rot = {i_valid, i_valid} >> i_ptr;

  // Find offset of first valid bit, then map back to an absolute index.
  always_comb begin
    o_found = 1'b0;
    w_off   = '0;
    w_cnt   = '0;
    w_scan  = w_rot[NUM_REQ-1:0];
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!o_found && w_scan[0]) begin
        o_found = 1'b1;
        w_off   = w_cnt;
      end
      w_scan = w_scan >> 1;
      w_cnt  = w_cnt + 1'b1;
    end
    w_sum = {1'b0, i_ptr} + w_off;
    if (w_sum >= NR) w_sum = w_sum - NR;
    o_winner = w_sum[ID_W-1:0];
  end

  // One-hot grant only when the downstream can take a result.
  always_comb begin
    o_grant = '0;
    if (o_found && i_enable) o_grant = NUM_REQ'(1) << o_winner;
  end

endmodule

// File: rtl/adder_rr_arbiter.sv
// Round-robin shared 32-bit adder with a single-entry response register.
// Optional macro ADDER_ARB_STATS_EN adds the stat_grants transfer counter.
module adder_rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_cin,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout,
  output logic                     rsp_overflow
`ifdef ADDER_ARB_STATS_EN
  ,
  output logic [31:0]              stat_grants
`endif
);

  localparam logic [ID_W:0] NR = (ID_W + 1)'(NUM_REQ);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  r_id;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_can_accept;
  logic             w_found;
  logic             w_xfer;
  logic [ID_W-1:0]  w_winner;
  logic [ID_W:0]    w_inc;
  logic [ID_W-1:0]  w_ptr_nxt;
  logic [WIDTH-1:0] w_a_arr [NUM_REQ];
  logic [WIDTH-1:0] w_b_arr [NUM_REQ];
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_cin;
  add_res_t         w_res;

  assign w_can_accept = (r_state == EMPTY) || rsp_ready;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .i_valid  (req_valid),
    .i_ptr    (r_ptr),
    .i_enable (w_can_accept),
    .o_grant  (req_ready),
    .o_winner (w_winner),
    .o_found  (w_found)
  );

  assign w_xfer = w_found && w_can_accept;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign w_a_arr[g] = req_a[g*WIDTH +: WIDTH];
    assign w_b_arr[g] = req_b[g*WIDTH +: WIDTH];
  end

  assign w_a   = w_a_arr[w_winner];
  assign w_b   = w_b_arr[w_winner];
  assign w_cin = req_cin[w_winner];
  assign w_res = add_calc(MAX_WIDTH'(w_a), MAX_WIDTH'(w_b), w_cin, WIDTH);

  // Pointer advances to the slot after the winner, wrapping at NUM_REQ.
  always_comb begin
    w_inc     = {1'b0, w_winner} + 1'b1;
    w_ptr_nxt = w_inc[ID_W-1:0];
    if (w_inc >= NR) w_ptr_nxt = '0;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Next state: fill on transfer, drain when consumed with no refill.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (w_xfer) w_state_nxt = FULL;
      FULL:    if (rsp_ready && !w_xfer) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  // Response register and round-robin pointer update on each transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_id   <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_ptr  <= '0;
    end else if (w_xfer) begin
      r_sum  <= w_res.sum[WIDTH-1:0];
      r_id   <= w_winner;
      r_cout <= w_res.cout;
      r_ovf  <= w_res.ovf;
      r_ptr  <= w_ptr_nxt;
    end
  end

  assign rsp_valid    = (r_state == FULL);
  assign rsp_id       = r_id;
  assign rsp_sum      = r_sum;
  assign rsp_cout     = r_cout;
  assign rsp_overflow = r_ovf;

`ifdef ADDER_ARB_STATS_EN
  logic [31:0] r_stat;

  // Free-running count of accepted requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_stat <= '0;
    else if (w_xfer) r_stat <= r_stat + 32'd1;
  end

  assign stat_grants = r_stat;
`endif

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed self-checking bench for adder_rr_arbiter (NUM_REQ=4, WIDTH=32).
module tb_adder_rr_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned WIDTH   = 32;
  localparam int unsigned ID_W    = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_cin;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH-1:0]         rsp_sum;
  logic                     rsp_cout;
  logic                     rsp_overflow;
`ifdef ADDER_ARB_STATS_EN
  logic [31:0]              stat_grants;
`endif

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int unsigned n_fail  = 0;

  adder_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .WIDTH   (WIDTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_cin      (req_cin),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_sum      (rsp_sum),
    .rsp_cout     (rsp_cout),
    .rsp_overflow (rsp_overflow)
`ifdef ADDER_ARB_STATS_EN
    ,
    .stat_grants  (stat_grants)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int unsigned i, input logic [31:0] a,
                         input logic [31:0] b, input logic cin);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_cin[i]              = cin;
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic [1:0] id,
                         input logic [31:0] sum, input logic co, input logic ov);
    chk({tag, "_valid"}, 64'(rsp_valid), 64'(v));
    chk({tag, "_id"},    64'(rsp_id),    64'(id));
    chk({tag, "_sum"},   64'(rsp_sum),   64'(sum));
    chk({tag, "_cout"},  64'(rsp_cout),  64'(co));
    chk({tag, "_ovf"},   64'(rsp_overflow), 64'(ov));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    rsp_ready = 1'b1;

    // Reset state
    #3;
    chk_rsp("reset", 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
    chk("reset_req_ready", 64'(req_ready), 64'h0);
    do_reset();

    // Round robin: requester i adds i+i, pointer starts at 0
    for (int i = 0; i < 4; i++) set_req(i, 32'(i), 32'(i), 1'b0);
    req_valid = 4'b1111;
    #1;
    chk("rr_ready0", 64'(req_ready), 64'h1);
    step(); chk_rsp("rr0", 1'b1, 2'd0, 32'd0, 1'b0, 1'b0);
    step(); chk_rsp("rr1", 1'b1, 2'd1, 32'd2, 1'b0, 1'b0);
    step(); chk_rsp("rr2", 1'b1, 2'd2, 32'd4, 1'b0, 1'b0);
    step(); chk_rsp("rr3", 1'b1, 2'd3, 32'd6, 1'b0, 1'b0);
    step(); chk_rsp("rr4", 1'b1, 2'd0, 32'd0, 1'b0, 1'b0);
    req_valid = '0;
    step(); chk("rr_drain", 64'(rsp_valid), 64'h0);

    // Single request with signed overflow (pointer is now 1, wraps to 0)
    set_req(0, 32'h7FFF_FFFF, 32'h1, 1'b0);
    req_valid = 4'b0001;
    #1;
    chk("single_ready", 64'(req_ready), 64'h1);
    step();
    req_valid = '0;
    chk_rsp("single", 1'b1, 2'd0, 32'h8000_0000, 1'b0, 1'b1);
    step(); chk("single_drain", 64'(rsp_valid), 64'h0);

    // Pointer fairness: grant 2, then 3,0,1 among {0,1,3}
    set_req(0, 32'd10, 32'd20, 1'b0);
    set_req(1, 32'd100, 32'd200, 1'b1);
    set_req(2, 32'd7, 32'd8, 1'b0);
    set_req(3, 32'hFFFF_FFFF, 32'd1, 1'b0);
    req_valid = 4'b0100;
    step(); chk_rsp("fair2", 1'b1, 2'd2, 32'd15, 1'b0, 1'b0);
    req_valid = 4'b1011;
    step(); chk_rsp("fair3", 1'b1, 2'd3, 32'd0, 1'b1, 1'b0);
    step(); chk_rsp("fair0", 1'b1, 2'd0, 32'd30, 1'b0, 1'b0);
    step(); chk_rsp("fair1", 1'b1, 2'd1, 32'd301, 1'b0, 1'b0);
    req_valid = '0;
    step(); chk("fair_drain", 64'(rsp_valid), 64'h0);

    // Backpressure: pointer at 2, requester 1 alone wins
    set_req(1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    set_req(0, 32'd1, 32'd2, 1'b0);
    set_req(3, 32'd40, 32'd2, 1'b1);
    req_valid = 4'b0010;
    step();
    chk_rsp("bp_load", 1'b1, 2'd1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    rsp_ready = 1'b0;
    req_valid = 4'b1001;
    #1;
    chk("bp_ready_hold0", 64'(req_ready), 64'h0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk_rsp("bp_hold", 1'b1, 2'd1, 32'h7FFF_FFFF, 1'b1, 1'b1);
      chk("bp_ready_hold", 64'(req_ready), 64'h0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(req_ready), 64'h8);
    step();
    chk_rsp("bp_next", 1'b1, 2'd3, 32'd43, 1'b0, 1'b0);
    req_valid = '0;
    step(); chk("bp_drain", 64'(rsp_valid), 64'h0);

    // Reset while FULL: 5 + (-3) = 2, pointer at 0
    set_req(2, 32'd5, 32'hFFFF_FFFD, 1'b0);
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    rsp_ready = 1'b0;
    chk_rsp("rst_full", 1'b1, 2'd2, 32'd2, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 64'(rsp_valid), 64'h0);
    chk("rst_async_sum", 64'(rsp_sum), 64'h0);
    #3;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 32'(i), 32'd1, 1'b0);
    req_valid = 4'b1111;
    #1;
    chk("rst_first_ready", 64'(req_ready), 64'h1);
    step();
    chk_rsp("rst_first", 1'b1, 2'd0, 32'd1, 1'b0, 1'b0);
    req_valid = '0;
    step();

`ifdef ADDER_ARB_STATS_EN
    // Stats: 10 transfers with 2 stall cycles
    do_reset();
    chk("stat_reset", 64'(stat_grants), 64'd0);
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) step();
    rsp_ready = 1'b0;
    step();
    step();
    chk("stat_stall", 64'(stat_grants), 64'd5);
    rsp_ready = 1'b1;
    for (int c = 0; c < 5; c++) step();
    req_valid = '0;
    step();
    chk("stat_ten", 64'(stat_grants), 64'd10);
    rst_n = 1'b0;
    #1;
    chk("stat_clear", 64'(stat_grants), 64'd0);
    rst_n = 1'b1;
    step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/adder_rr_arbiter.md
Name: adder_rr_arbiter

Overview:
- Shares one combinational 32-bit two's-complement adder among NUM_REQ independent requesters.
- Round-robin arbitration selects one requester per cycle. The chosen operands are added and the result is held in a single-entry response register under a valid/ready handshake.
- Sits between multiple datapath clients, such as multiplier partial-sum stages, and a single adder instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 32, operand/sum width in bits.
- ID_W, $clog2(NUM_REQ), width of requester index.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester grant; one-hot or zero.
- req_a  input  NUM_REQ*WIDTH  operand A; slice i belongs to requester i.
- req_b  input  NUM_REQ*WIDTH  operand B, packed as req_a.
- req_cin  input  NUM_REQ  carry-in per requester.
- rsp_valid  output  1  response register holds a result.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  ID_W  index of the requester that produced the result.
- rsp_sum  output  WIDTH  sum.
- rsp_cout  output  1  carry out of bit WIDTH-1.
- rsp_overflow  output  1  signed overflow.
- stat_grants  output  32  only with ADDER_ARB_STATS_EN; total accepted requests.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, rsp_overflow=0, rr_ptr=0, FSM=EMPTY.
- FSM states:
  - EMPTY: response register empty.
  - FULL: response register holds a result.
- can_accept = (state==EMPTY) || rsp_ready.
- Arbitration (combinational):
  - If can_accept and any req_valid, the winner is the first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... with wrap modulo NUM_REQ.
  - req_ready = one-hot(winner); otherwise req_ready = 0.
  - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
- Transfer: a request transfers when req_valid[i] && req_ready[i]. On that rising edge:
  - rsp_sum <= (a + b + cin) mod 2^WIDTH.
  - rsp_cout <= bit WIDTH of the (WIDTH+1)-bit sum.
  - rsp_overflow <= (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]).
  - rsp_id <= winner.
  - rsp_valid <= 1; FSM -> FULL.
  - rr_ptr <= (winner+1) mod NUM_REQ.
- Latency and throughput:
  - Latency is 1 cycle from transfer to rsp_valid.
  - Throughput is 1 result/cycle while rsp_ready=1.
- FULL state:
  - rsp_ready=1 with no new transfer in the same cycle: rsp_valid <= 0, FSM -> EMPTY.
  - rsp_ready=1 with a new transfer in the same cycle: the response register reloads and stays FULL. This is back-to-back operation with no bubble.
  - rsp_ready=0: all rsp_* outputs remain stable, req_ready=0, and rr_ptr is unchanged.
- No valid request: rr_ptr is unchanged and the response register is unaffected.
- Starvation bound: a requester holding req_valid is granted within NUM_REQ accepting cycles.
- Reset mid-operation: the held result is discarded without being delivered. All state returns to reset values asynchronously.
- The adder is purely combinational on the winner's muxed operands. There is no other state.

Optional Feature:
- ADDER_ARB_STATS_EN defined:
  - Adds the 32-bit free-running counter stat_grants and its port.
  - Reset to 0; incremented by 1 on every transfer; wraps from 2^32-1 to 0.
- ADDER_ARB_STATS_EN undefined: the counter and the port are absent. All other behaviour is identical.

Decomposition:
- Shared package adder_arb_pkg holds:
  - FSM state typedef {EMPTY, FULL}.
  - Default WIDTH/NUM_REQ constants.
  - A function computing {cout, sum, overflow} from a, b, cin.
- Natural sub-module: rr_priority_picker. It is combinational and maps (req_valid, rr_ptr) to one-hot grant plus winner index.

Test Plan:
- Single request: req0 a=32'h7FFFFFFF, b=1, cin=0, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, sum=32'h80000000, cout=0, overflow=1.
- Round-robin order: all 4 valid continuously, rsp_ready=1, requester i adds i+i with cin=0 -> rsp_id sequence 0,1,2,3,0 on consecutive cycles, sums 0,2,4,6,0, no bubbles.
- Pointer fairness: grant to 2 with only req2 valid; then req0, req1 and req3 valid -> next grants 3, 0, 1.
- Backpressure: requester 1 a=32'h80000000, b=32'hFFFFFFFF, then rsp_ready=0 for 3 cycles with other requests pending:
  - Response holds sum=32'h7FFFFFFF, cout=1, overflow=1, stable.
  - req_ready=0 throughout.
  - On rsp_ready=1 the next winner transfers in the same cycle.
- Reset mid-FULL: rsp_valid=1 holding 5+(-3)=2; assert rst_n=0 between edges -> rsp_valid=0, rsp_sum=0 immediately; after release the first grant goes to req0.
- Stats (macro defined): 10 transfers with 2 stall cycles -> stat_grants=10; reset -> 0.
